// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch path.
// Each buffered entry pairs a fetched word with the byte address it came from.
package fetch_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0004;
  localparam int          INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetched instructions; flush empties it and wins over push.
// The head is combinational from the read pointer and reads as zero while empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only visible once r_count covers it, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator: owns the PC, issues one word address per cycle under a credit limit,
// tags returning words with their PC and hands them to decode over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_STEP  = 32'(INSTR_BYTES)
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  logic          w_pop;
  logic          w_issue;
  logic          w_push;
  logic [31:0]   w_target;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_head;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_pop       = 1'b0;
    w_occupancy = '0;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_target    = '0;
    w_push_data = '0;

    w_pop       = (w_count != '0) && instr_ready;
    // Buffered + in-flight words after this cycle's pop must leave room for one more request.
    w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    w_issue     = !redirect_valid && (w_occupancy < (CW+1)'(DEPTH));
    w_push      = r_inflight && !redirect_valid;
    w_target    = redirect_pc & 32'hFFFF_FFFC;
    w_push_data.word = imem_word;
    w_push_data.pc   = r_inflight_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + PC_STEP;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (w_count != '0);
  assign instr_word  = w_head.word;
  assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: startup stream, backpressure, redirect, PC wrap,
// mid-stream reset and a randomized ready/redirect run against a sequential-PC scoreboard.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_word = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_word      (imem_word),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'd4:   return 32'h0010_0093;
      32'd8:   return 32'h0020_0113;
      32'd12:  return 32'h0030_0193;
      32'd16:  return 32'h0040_0213;
      32'd20:  return 32'h0040_0F93;
      32'd24:  return 32'h0090_8293;
      32'd32:  return 32'h01F2_F313;
      32'd52:  return 32'h0052_2223;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) imem_word <= mem_f(imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
  endtask

  // Called on the negedge where rst_n has just been released.
  task automatic run_startup(input string tag);
    logic [31:0] exp_w [8];
    logic [64:0] obs, exp;
    exp_w = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213,
              32'h0040_0F93, 32'h0090_8293, 32'h0000_0000, 32'h01F2_F313};
    instr_ready = 1'b1;
    step();
    n_vec++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'h8}) begin
      n_miss++;
      $display("FAIL %s_cycle2: valid/addr got %0b/%h, need 0/00000008", tag, instr_valid, imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      obs = {instr_valid, instr_pc, instr_word};
      exp = {1'b1, 32'(4 + 4 * i), exp_w[i]};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL %s_stream%0d: {v,pc,word} got %h, need %h", tag, i, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({instr_valid, instr_pc, instr_word, imem_addr} !== {65'd0, 32'h4}) begin
      n_miss++;
      $display("FAIL reset_state: v=%0b pc=%h word=%h addr=%h, need 0/0/0/00000004",
               instr_valid, instr_pc, instr_word, imem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_release();
    apply_reset();
    rst_n = 1'b1;
    run_startup("start");
  endtask

  task automatic test_backpressure();
    logic [64:0] obs, exp;
    apply_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs = {instr_valid, instr_pc, instr_word};
      exp = {1'b1, 32'h4, 32'h0010_0093};
      n_vec++;
      if (obs !== exp || imem_addr !== 32'hC) begin
        n_miss++;
        $display("FAIL bp_hold%0d: {v,pc,word} got %h addr %h, need %h addr 0000000c", i, obs, imem_addr, exp);
      end
      if (i >= 1) begin
        n_vec++;
        if (dut.w_count !== 2'd2) begin
          n_miss++;
          $display("FAIL bp_count%0d: count got %0d, need 2", i, dut.w_count);
        end
      end
      if (i < 5) step();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {instr_valid, instr_pc, instr_word};
      exp = {1'b1, 32'(8 + 4 * i), mem_f(32'(8 + 4 * i))};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL bp_release%0d: {v,pc,word} got %h, need %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_redirect();
    logic [64:0] obs, exp;
    apply_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    step();
    n_vec++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h8}) begin
      n_miss++;
      $display("FAIL redir_pre: v/pc got %0b/%h, need 1/00000008", instr_valid, instr_pc);
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    n_vec++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'h20}) begin
      n_miss++;
      $display("FAIL redir_next: v/addr got %0b/%h, need 0/00000020", instr_valid, imem_addr);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    step();
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL redir_gap: valid got %0b, need 0", instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {instr_valid, instr_pc, instr_word};
      exp = {1'b1, 32'(32 + 4 * i), mem_f(32'(32 + 4 * i))};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL redir_stream%0d: {v,pc,word} got %h, need %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    logic [64:0] obs, exp;
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    apply_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    n_vec++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'hFFFF_FFF8}) begin
      n_miss++;
      $display("FAIL wrap_next: v/addr got %0b/%h, need 0/fffffff8", instr_valid, imem_addr);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {instr_valid, instr_pc, instr_word};
      exp = {1'b1, exp_pc[i], mem_f(exp_pc[i])};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL wrap_stream%0d: {v,pc,word} got %h, need %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    instr_ready = 1'b0;
    step();
    n_vec++;
    if (dut.w_count !== 2'd2) begin
      n_miss++;
      $display("FAIL mrst_full: count got %0d, need 2", dut.w_count);
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if ({instr_valid, instr_pc, instr_word, imem_addr} !== {65'd0, 32'h4}) begin
      n_miss++;
      $display("FAIL mrst_state: v=%0b pc=%h word=%h addr=%h, need 0/0/0/00000004",
               instr_valid, instr_pc, instr_word, imem_addr);
    end
    rst_n = 1'b1;
    run_startup("restart");
  endtask

  task automatic test_random();
    logic [31:0] targets [5];
    logic [31:0] exp_pc;
    logic [64:0] obs, exp;
    logic        rdy, redir, was_redir;
    int          pops;
    targets   = '{32'h4, 32'h8, 32'h22, 32'h30, 32'hFFFF_FFFC};
    apply_reset();
    rst_n     = 1'b1;
    exp_pc    = 32'h4;
    pops      = 0;
    was_redir = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (was_redir) begin
        n_vec++;
        if (instr_valid !== 1'b0) begin
          n_miss++;
          $display("FAIL rand_flush%0d: valid got %0b, need 0", cyc, instr_valid);
        end
      end
      rdy   = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 7) == 0);
      if (instr_valid && rdy) begin
        obs = {instr_valid, instr_pc, instr_word};
        exp = {1'b1, exp_pc, mem_f(exp_pc)};
        n_vec++;
        if (obs !== exp) begin
          n_miss++;
          $display("FAIL rand_pop%0d: {v,pc,word} got %h, need %h", cyc, obs, exp);
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redir) begin
        redirect_pc = targets[$urandom_range(0, 4)];
        exp_pc      = redirect_pc & 32'hFFFF_FFFC;
      end
      redirect_valid = redir;
      instr_ready    = rdy;
      was_redir      = redir;
      step();
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    n_vec++;
    if (pops < 20) begin
      n_miss++;
      $display("FAIL rand_progress: accepted got %0d, need >= 20", pops);
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the synchronous instruction memory.
- Owns the program counter and drives the word address to instruction memory, which returns a 32-bit word one clock later.
- Tags each returned word with its PC and buffers it in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; supports backpressure and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0004: PC loaded on reset. The first program instruction lives at byte address 4.
- DEPTH, 2: instruction buffer entries, >=2. Also the outstanding-request credit limit.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  32  byte address to instruction memory; registered.
- imem_word  in  32  memory read data; equals mem[imem_addr sampled at previous rising edge].
- instr_valid  out  1  buffer head holds a valid instruction.
- instr_ready  in  1  decode accepts head this cycle.
- instr_word  out  32  instruction at buffer head.
- instr_pc  out  32  byte address of instr_word.
- redirect_valid  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.

Behaviour:
- Reset: when rst_n=0 at an edge:
  - fetch_pc <= RESET_PC (drives imem_addr).
  - inflight <= 0, count <= 0, rd/wr pointers <= 0.
  - instr_valid=0; instr_word and instr_pc = 0 while empty.
  - Reset mid-operation discards all buffered and in-flight words.
- Memory model: the memory reads every cycle and has no enable. The response visible in cycle n+1 is for the address held in cycle n.
  - State flag inflight (1 bit) and inflight_pc mark whether that response is wanted.
- pop = instr_valid & instr_ready.
- issue = !redirect_valid & (count + inflight - pop < DEPTH). Combinational credit check.
- On issue at an edge: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP.
  - Wraps 32'hFFFF_FFFC -> 0, modulo 2^32, no flag.
- No issue: inflight <= 0; fetch_pc holds.
- Capture: if inflight=1 in a cycle and no redirect, push {imem_word, inflight_pc} at the edge.
- Credit rule guarantees the push never overflows. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Head output: combinational from the FIFO read pointer. The head is stable while instr_valid=1 and instr_ready=0 (AXI-style hold).
- Redirect (priority over everything, including a same-cycle pop/push):
  - At the edge: count <= 0, inflight <= 0, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The head popped in that cycle counts as accepted.
  - Next cycle: instr_valid=0 and imem_addr = target.
  - The target word appears at instr_valid 2 cycles after the redirect edge.
- Latency: first post-reset cycle issues RESET_PC; instr_valid rises 2 cycles later.
- Throughput: 1 instr/cycle with instr_ready held high.
- Words of 0 (e.g. unpopulated addresses) are passed through unchanged; there is no decode here.
- No X on outputs after reset.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] word; logic [31:0] pc;}
  - localparam PC_RESET_DEFAULT = 32'h4
  - localparam INSTR_BYTES = 4
- One sub-module: fetch_buffer, a DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, push_data, pop, flush, head, count.
  - Flush takes priority over push.
- PC/credit logic stays in instr_fetch_unit.

Test Plan:
- Bench model memory: 4->00100093, 8->00200113, 12->00300193, 16->00400213, 20->00400F93, 24->00908293, 28->0, 32->01F2F313, 52->00522223, others 0.
- Reset release, instr_ready=1 -> instr_valid rises on 3rd cycle after release; stream (pc,word) = (4,00100093),(8,00200113),(12,00300193)... one per cycle; (28,00000000) appears in order.
- instr_ready=0 for 5 cycles after first valid -> head holds (4,00100093); count=2; imem_addr frozen at 12. On release, 8 and 12 follow back-to-back with no gap or duplicate.
- redirect_valid for 1 cycle with redirect_pc=32'h22, while 8 is at head and 12 is in flight -> next cycle instr_valid=0, imem_addr=32'h20. Then (32,01F2F313),(36,...) with no stale 8/12.
- Redirect in the same cycle as pop, with instr_ready toggling randomly for 200 cycles -> scoreboard sees no loss or duplicate.
- Redirect to 32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0, 4; word at pc 4 = 00100093.
- rst_n=0 for 1 cycle mid-stream with buffer full -> next cycle instr_valid=0, imem_addr=4; restart sequence identical to scenario 1.
